// File: rtl/dff_reg_arbiter_if.sv
// dff_reg_arbiter_if: requester/register bundle for the shared-register
// write arbiter. The lock vector exists only when DFF_REG_ARB_LOCK_EN is defined.
interface dff_reg_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 16
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] D;
`ifdef DFF_REG_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       lock;
`endif
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         Q;
  logic                     busy;
  logic [CNT_W-1:0]         wr_cnt;

  // producer side
  modport master (
    output req,
    output D,
`ifdef DFF_REG_ARB_LOCK_EN
    output lock,
`endif
    input  gnt,
    input  Q,
    input  busy,
    input  wr_cnt
  );

  // arbiter side
  modport slave (
    input  req,
    input  D,
`ifdef DFF_REG_ARB_LOCK_EN
    input  lock,
`endif
    output gnt,
    output Q,
    output busy,
    output wr_cnt
  );
endinterface

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: round-robin write arbiter in front of a shared WIDTH-bit
// register. One write per clock; the winner's lane is loaded into Q, a
// one-cycle one-hot gnt acknowledges it and wr_cnt counts accepted writes
// (saturating). Optional macro DFF_REG_ARB_LOCK_EN adds a per-requester lock
// that lets a winner keep exclusive ownership of the write slot.
module dff_reg_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input logic               clk,
  input logic               reset,
  dff_reg_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] elig;
  logic               win_vld;
  logic [PTR_W-1:0]   win;
  logic [WIDTH-1:0]   win_data;
  logic               ptr_load;
  logic [PTR_W-1:0]   ptr_load_val;

  logic [WIDTH-1:0]   q_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
    if (i == PTR_W'(NUM_REQ - 1)) return '0;
    return i + 1'b1;
  endfunction

`ifdef DFF_REG_ARB_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t      state, state_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic             owner_hold;

  assign owner_hold = bus.req[owner] & bus.lock[owner];

  // lock FSM state and owner registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= UNLOCKED;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // while locked only the owner competes; everyone else stalls
  always_comb begin
    elig = bus.req;
    if (state == LOCKED) begin
      elig        = '0;
      elig[owner] = owner_hold;
    end
  end

  // lock next state and pointer update; the release edge is a no-write
  // edge because only the (now absent) owner could have won it
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    ptr_load     = 1'b0;
    ptr_load_val = ptr;
    case (state)
      UNLOCKED: begin
        if (win_vld) begin
          ptr_load     = 1'b1;
          ptr_load_val = wrap_inc(win);
          if (bus.lock[win]) begin
            state_nxt = LOCKED;
            owner_nxt = win;
          end
        end
      end
      LOCKED: begin
        if (!owner_hold) begin
          state_nxt    = UNLOCKED;
          ptr_load     = 1'b1;
          ptr_load_val = wrap_inc(owner);
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end
`else
  assign elig         = bus.req;
  assign ptr_load     = win_vld;
  assign ptr_load_val = wrap_inc(win);
`endif

  // round-robin search starting at ptr, wrapping modulo NUM_REQ
  always_comb begin
    int unsigned idx;
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && elig[PTR_W'(idx)]) begin
        win_vld = 1'b1;
        win     = PTR_W'(idx);
      end
    end
  end

  // select the winning requester's data lane
  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win == PTR_W'(k)) win_data = bus.D[k*WIDTH +: WIDTH];
    end
  end

  // shared register, grant pulse, busy flag, write counter and pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= '0;
      gnt_r  <= '0;
      busy_r <= 1'b0;
      cnt_r  <= '0;
      ptr    <= '0;
    end else begin
      busy_r <= |bus.req;
      gnt_r  <= '0;
      if (win_vld) begin
        q_r        <= win_data;
        gnt_r[win] <= 1'b1;
        if (cnt_r != '1) cnt_r <= cnt_r + 1'b1;
      end
      if (ptr_load) ptr <= ptr_load_val;
    end
  end

  assign bus.Q      = q_r;
  assign bus.gnt    = gnt_r;
  assign bus.busy   = busy_r;
  assign bus.wr_cnt = cnt_r;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb_dff_reg_arbiter: directed and randomized checks of dff_reg_arbiter
// against a behavioural model. A second instance with CNT_W=4 shares the
// stimulus to exercise counter saturation.
module tb_dff_reg_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dff_reg_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(16)) bus ();
  dff_reg_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(4))  sbus ();

  dff_reg_arbiter #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  dff_reg_arbiter #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .bus(sbus.slave));

  assign sbus.req = bus.req;
  assign sbus.D   = bus.D;
`ifdef DFF_REG_ARB_LOCK_EN
  assign sbus.lock = bus.lock;
`endif

  always #5 clk = ~clk;

  // behavioural reference state
  int           m_ptr, m_cnt, m_cnt4, m_owner;
  bit           m_locked;
  logic [7:0]   m_q;
  logic [3:0]   m_gnt;
  logic         m_busy;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NR; k++)
      if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic void m_write(input int w, input logic [31:0] d);
    m_q   = d[w*8 +: 8];
    m_gnt = 4'(1 << w);
    m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : 65535;
    m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
  endfunction

  function automatic void model_edge();
    logic [3:0]  r;
    logic [31:0] d;
    logic [3:0]  lk;
    int          w;
    r = bus.req;
    d = bus.D;
`ifdef DFF_REG_ARB_LOCK_EN
    lk = bus.lock;
`else
    lk = '0;
`endif
    if (reset) begin
      m_q = '0; m_gnt = '0; m_busy = 1'b0; m_cnt = 0; m_cnt4 = 0;
      m_ptr = 0; m_locked = 0; m_owner = 0;
      return;
    end
    m_busy = (r != 0);
    m_gnt  = '0;
    if (m_locked) begin
      if (r[m_owner] && lk[m_owner]) m_write(m_owner, d);
      else begin
        m_locked = 0;
        m_ptr = (m_owner + 1) % NR;
      end
    end else begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_write(w, d);
        m_ptr = (w + 1) % NR;
        if (lk[w]) begin
          m_locked = 1;
          m_owner  = w;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [31:0] d);
    bus.req = r;
    bus.D   = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'b0000, 32'h0);
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'b1111, 32'hFFFF_FFFF);
    step();
    checks++;
    if (bus.Q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", bus.Q); end
    checks++;
    if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
    checks++;
    if (bus.wr_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.wr_cnt); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    reset = 1'b0;
    step();
    checks++;
    if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL post_reset_gnt got %b exp 0001", bus.gnt); end
    checks++;
    if (bus.Q !== 8'hFF) begin errors++; $display("FAIL post_reset_q got %h exp ff", bus.Q); end
  endtask

  task automatic test_single();
    do_reset();
    drive(4'b0100, 32'h00A5_0000);
    step();
    checks++;
    if (bus.Q !== 8'hA5) begin errors++; $display("FAIL single_q got %h exp a5", bus.Q); end
    checks++;
    if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", bus.gnt); end
    checks++;
    if (bus.wr_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", bus.wr_cnt); end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", bus.busy); end
    drive(4'b0000, 32'h1234_5678);
    step();
    checks++;
    if (bus.Q !== 8'hA5) begin errors++; $display("FAIL single_hold_q got %h exp a5", bus.Q); end
    checks++;
    if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_idle_gnt got %b exp 0000", bus.gnt); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_rotation();
    logic [3:0] eg;
    logic [7:0] eq;
    do_reset();
    drive(4'b1111, 32'h4030_2010);
    for (int i = 0; i < 8; i++) begin
      step();
      eg = 4'(1 << (i % 4));
      eq = 8'(8'h10 * ((i % 4) + 1));
      checks++;
      if (bus.gnt !== eg) begin errors++; $display("FAIL rot_gnt[%0d] got %b exp %b", i, bus.gnt, eg); end
      checks++;
      if (bus.Q !== eq) begin errors++; $display("FAIL rot_q[%0d] got %h exp %h", i, bus.Q, eq); end
    end
    checks++;
    if (bus.wr_cnt !== 16'd8) begin errors++; $display("FAIL rot_cnt got %0d exp 8", bus.wr_cnt); end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    drive(4'b0100, 32'h0);
    step();                                   // ptr -> 3
    drive(4'b0011, 32'h0000_BBAA);
    step();
    checks++;
    if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0 got %b exp 0001", bus.gnt); end
    step();
    checks++;
    if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL wrap_gnt1 got %b exp 0010", bus.gnt); end
    checks++;
    if (bus.Q !== 8'hBB) begin errors++; $display("FAIL wrap_q got %h exp bb", bus.Q); end
    do_reset();
    drive(4'b0001, 32'h0);
    step();                                   // ptr -> 1
    drive(4'b1001, 32'hDD00_00CC);
    step();
    checks++;
    if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL skip_gnt got %b exp 1000", bus.gnt); end
    checks++;
    if (bus.Q !== 8'hDD) begin errors++; $display("FAIL skip_q got %h exp dd", bus.Q); end
  endtask

  task automatic test_saturation();
    int e;
    do_reset();
    drive(4'b0001, 32'h0000_0077);
    for (int i = 0; i < 20; i++) begin
      step();
      e = (i + 1 < 15) ? i + 1 : 15;
      checks++;
      if (sbus.wr_cnt !== 4'(e)) begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, sbus.wr_cnt, e); end
    end
    checks++;
    if (bus.wr_cnt !== 16'd20) begin errors++; $display("FAIL wide_cnt got %0d exp 20", bus.wr_cnt); end
  endtask

`ifdef DFF_REG_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.lock = 4'b0000;
    drive(4'b0001, 32'h0);
    step();                                   // ptr -> 1
    drive(4'b1111, 32'h4030_2010);
    bus.lock = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL lock_gnt[%0d] got %b exp 0010", i, bus.gnt); end
    end
    bus.lock = 4'b0000;
    step();                                   // release edge: no write
    checks++;
    if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL lock_release_gnt got %b exp 0000", bus.gnt); end
    step();
    checks++;
    if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL lock_after_gnt got %b exp 0100", bus.gnt); end
    checks++;
    if (bus.wr_cnt !== 16'd5) begin errors++; $display("FAIL lock_cnt got %0d exp 5", bus.wr_cnt); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(4'($urandom), $urandom);
`ifdef DFF_REG_ARB_LOCK_EN
      bus.lock = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
`endif
      step();
      checks++;
      if (bus.Q !== m_q) begin errors++; $display("FAIL rand_q[%0d] got %h exp %h", i, bus.Q, m_q); end
      checks++;
      if (bus.gnt !== m_gnt) begin errors++; $display("FAIL rand_gnt[%0d] got %b exp %b", i, bus.gnt, m_gnt); end
      checks++;
      if (bus.busy !== m_busy) begin errors++; $display("FAIL rand_busy[%0d] got %b exp %b", i, bus.busy, m_busy); end
      checks++;
      if (bus.wr_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d] got %0d exp %0d", i, bus.wr_cnt, m_cnt); end
      checks++;
      if (sbus.wr_cnt !== 4'(m_cnt4)) begin errors++; $display("FAIL rand_cnt4[%0d] got %0d exp %0d", i, sbus.wr_cnt, m_cnt4); end
      checks++;
      if ($isunknown(bus.gnt) || $countones(bus.gnt) > 1) begin
        errors++; $display("FAIL rand_onehot[%0d] got %b exp at most one bit", i, bus.gnt);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b0000, 32'h0);
`ifdef DFF_REG_ARB_LOCK_EN
    bus.lock = 4'b0000;
`endif
    m_ptr = 0; m_cnt = 0; m_cnt4 = 0; m_owner = 0; m_locked = 0;
    m_q = '0; m_gnt = '0; m_busy = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_wrap_skip();
    test_saturation();
`ifdef DFF_REG_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dff_reg_arbiter.md
Name: dff_reg_arbiter

Overview:
- Round-robin write arbiter in front of a shared WIDTH-bit register. The register is built from synchronous-reset D flip-flops.
- NUM_REQ requesters compete for one write slot per clock. The winner's data is loaded into the shared register Q.
- A one-hot, one-cycle grant pulse acknowledges the write. A saturating counter tracks how many writes were accepted.
- Sits between multiple producer blocks and the shared register cell used across the design.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data width of each requester and of Q.
- CNT_W, 16, width of the accepted-write counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
- req  input  NUM_REQ  per-requester write request, level-sensitive.
- D  input  NUM_REQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  registered one-hot grant pulse; bit i high for exactly one cycle after requester i's write is accepted.
- Q  output  WIDTH  shared register contents.
- busy  output  1  registered; high if any req was high at the last edge.
- wr_cnt  output  CNT_W  count of accepted writes, saturates at all-ones.

Behaviour:
- Reset (reset=1 at a rising edge):
  - Q=0, gnt=0, busy=0, wr_cnt=0.
  - Priority pointer ptr=0.
  - In ARB_LOCK_EN builds, lock state returns to UNLOCKED.
  - Reset overrides any simultaneous request; no write occurs on that edge.
- Arbitration:
  - Combinational search from index ptr upward, wrapping modulo NUM_REQ. The first set req bit is the winner w.
- Edge action when reset=0 and req≠0:
  - Q ← D slice w.
  - gnt ← one-hot(w).
  - ptr ← (w+1) mod NUM_REQ; wrap from NUM_REQ-1 goes to 0.
  - wr_cnt increments by 1 unless it is already all-ones (saturates, no wrap).
- Edge action when req=0: Q holds, gnt ← 0, ptr holds, wr_cnt holds.
- Latency: data presented with req at edge N appears on Q after edge N. gnt is high during cycle N to N+1.
- Requester handshake:
  - A requester must keep req and its data stable until it sees its gnt bit. It may drop req in the cycle gnt is high.
  - A req still high during its own gnt cycle is treated as a new request.
- Fairness: with all requesters continuously asserting, grants rotate 0,1,2,3,0,… Each requester waits at most NUM_REQ-1 cycles.
- Exactly one gnt bit is high per cycle at most. gnt is never X after reset.
- Reset mid-stream: pending requests are discarded. Arbitration restarts from ptr=0 on the first edge with reset=0.

Optional Feature:
- Macro: DFF_REG_ARB_LOCK_EN.
- Enabled:
  - Adds input port lock (NUM_REQ bits) and a 2-state FSM: UNLOCKED, LOCKED(owner).
  - In UNLOCKED, a winner whose lock bit is set moves the FSM to LOCKED with owner=w.
  - In LOCKED, only the owner can win. Other requests stall, and ptr is frozen.
  - The FSM returns to UNLOCKED on an edge where the owner's req=0 or lock=0. ptr is then set to owner+1.
- Disabled: no lock port, and behaviour is exactly as above.

Test Plan:
- Reset with req=4'b1111 and all D lanes=8'hFF -> after edge Q=8'h00, gnt=0, wr_cnt=0. The first post-reset edge grants requester 0.
- Single requester: req=4'b0100, D lane2=8'hA5 -> after one edge Q=8'hA5 and gnt=4'b0100 for one cycle, wr_cnt=1. With req then at 0, Q stays 8'hA5.
- All four requesting for 8 edges with lanes 8'h10,8'h20,8'h30,8'h40 -> gnt sequence 0001,0010,0100,1000 repeated twice. Q follows 10,20,30,40,… and wr_cnt=8.
- Wrap and skip: ptr=3, req=4'b0011 -> winner 0, then 1. With req=4'b1001 and ptr=1 -> winner 3.
- Saturation: CNT_W=4, 20 consecutive writes -> wr_cnt stops at 4'hF.
- With DFF_REG_ARB_LOCK_EN: requester 1 holds lock for 3 edges while req=4'b1111 -> gnt=0010 on 3 consecutive cycles. After release the next grant goes to requester 2.
